// File: rtl/seg_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module  : seg_stream_decoder
// Brief   : Debounces and decodes 7-segment display lines and reassembles
//           the blank-separated dice1/dice2 pair.
// Revision: 1.0 - initial release
// ============================================================================
module seg_stream_decoder #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg,
   input  logic       common_cathode,
   input  logic       err_clr,
   output logic       sym_valid,
   output logic [3:0] sym_code,
   output logic       pair_valid,
   output logic [3:0] dice1,
   output logic [3:0] dice2,
   output logic       timeout,
   output logic       err,
   output logic [1:0] err_cause
);

   localparam logic [7:0]  c_STABLE  = 8'(STABLE_CYCLES);
   localparam logic [19:0] c_TIMEOUT = 20'(TIMEOUT_CYCLES);
   localparam logic [3:0]  c_BLANK   = 4'hA;
   localparam logic [3:0]  c_INVALID = 4'hF;

   typedef enum logic [2:0] {
      ST_SYNC    = 3'd0,
      ST_WAIT_D1 = 3'd1,
      ST_SEP     = 3'd2,
      ST_WAIT_D2 = 3'd3,
      ST_END     = 3'd4
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [6:0]  w_n, r_samp;
   logic [7:0]  r_run;
   logic [3:0]  w_code, r_last;
   logic        r_last_vld;
   logic [3:0]  r_d1, r_d2, w_d1_nxt, w_d2_nxt;
   logic [19:0] r_idle;
   logic        w_accept, w_timeout, w_pair, w_is_digit, w_new_err;
   logic [1:0]  w_new_cause;

   assign w_n = common_cathode ? seg : ~seg;

   always_comb begin
      w_code = c_INVALID;
      case (r_samp)
         7'h3F: w_code = 4'd0;
         7'h06: w_code = 4'd1;
         7'h5B: w_code = 4'd2;
         7'h4F: w_code = 4'd3;
         7'h66: w_code = 4'd4;
         7'h6D: w_code = 4'd5;
         7'h7D: w_code = 4'd6;
         7'h07: w_code = 4'd7;
         7'h7F: w_code = 4'd8;
         7'h6F: w_code = 4'd9;
         7'h00: w_code = c_BLANK;
         default: w_code = c_INVALID;
      endcase
   end

   // A symbol is taken once its run has saturated, and only if it differs
   // from the previous accepted one, so a held pattern yields a single pulse.
   assign w_accept   = (r_run == c_STABLE) && (!r_last_vld || (w_code != r_last));
   assign w_is_digit = (w_code <= 4'd9);
   assign w_timeout  = !w_accept && (r_state != ST_SYNC) &&
                       (({1'b0, r_idle} + 21'd1) == {1'b0, c_TIMEOUT});

   always_comb begin
      w_state_nxt = r_state;
      w_d1_nxt    = r_d1;
      w_d2_nxt    = r_d2;
      w_pair      = 1'b0;
      w_new_err   = 1'b0;
      w_new_cause = 2'b00;
      if (w_accept) begin
         if (w_code == c_INVALID) begin
            w_new_err   = 1'b1;
            w_new_cause = 2'b01;
            w_state_nxt = ST_SYNC;
         end else begin
            case (r_state)
               ST_SYNC: begin
                  if (!w_is_digit) w_state_nxt = ST_WAIT_D1;
               end
               ST_WAIT_D1: begin
                  if (w_is_digit) begin
                     w_d1_nxt    = w_code;
                     w_state_nxt = ST_SEP;
                  end
               end
               ST_SEP, ST_END: begin
                  if (w_is_digit) begin
                     w_new_err   = 1'b1;
                     w_new_cause = 2'b10;
                     w_state_nxt = ST_SYNC;
                  end else if (r_state == ST_SEP) begin
                     w_state_nxt = ST_WAIT_D2;
                  end else begin
                     w_pair      = 1'b1;
                     w_state_nxt = ST_WAIT_D1;
                  end
               end
               ST_WAIT_D2: begin
                  if (w_is_digit) begin
                     w_d2_nxt    = w_code;
                     w_state_nxt = ST_END;
                  end
               end
               default: w_state_nxt = ST_SYNC;
            endcase
         end
      end else if (w_timeout) begin
         w_state_nxt = ST_SYNC;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_samp     <= '0;
         r_run      <= '0;
         r_last     <= '0;
         r_last_vld <= 1'b0;
         r_state    <= ST_SYNC;
         r_d1       <= '0;
         r_d2       <= '0;
         r_idle     <= '0;
         sym_valid  <= 1'b0;
         sym_code   <= '0;
         pair_valid <= 1'b0;
         dice1      <= '0;
         dice2      <= '0;
         timeout    <= 1'b0;
         err        <= 1'b0;
         err_cause  <= '0;
      end else begin
         r_samp <= w_n;
         if (w_n != r_samp)
            r_run <= 8'd1;
         else if (r_run != c_STABLE)
            r_run <= r_run + 8'd1;

         sym_valid  <= w_accept;
         pair_valid <= w_pair;
         timeout    <= w_timeout;
         if (w_accept) begin
            sym_code   <= w_code;
            r_last     <= w_code;
            r_last_vld <= 1'b1;
         end

         r_state <= w_state_nxt;
         r_d1    <= w_d1_nxt;
         r_d2    <= w_d2_nxt;
         if (w_pair) begin
            dice1 <= r_d1;
            dice2 <= r_d2;
         end

         // In SYNC the idle count parks at the limit without firing.
         if (w_accept || w_timeout)
            r_idle <= '0;
         else if (r_idle != c_TIMEOUT)
            r_idle <= r_idle + 20'd1;

         if (w_new_err) begin
            err       <= 1'b1;
            err_cause <= (err && !err_clr) ? err_cause : w_new_cause;
         end else if (err_clr) begin
            err       <= 1'b0;
            err_cause <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_stream_decoder
// Brief   : Directed and randomized checks of seg_stream_decoder against a
//           window/queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg_stream_decoder;

   localparam int STABLE = 4;
   localparam int TMO    = 20;

   logic       clk = 1'b0;
   logic       rst, common_cathode, err_clr;
   logic [6:0] seg;
   logic       sym_valid, pair_valid, timeout, err;
   logic [3:0] sym_code, dice1, dice2;
   logic [1:0] err_cause;

   seg_stream_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .seg(seg), .common_cathode(common_cathode),
      .err_clr(err_clr), .sym_valid(sym_valid), .sym_code(sym_code),
      .pair_valid(pair_valid), .dice1(dice1), .dice2(dice2),
      .timeout(timeout), .err(err), .err_cause(err_cause)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic [6:0] c_pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   // reference model state
   logic [6:0] hist [$];
   int         m_state;          // 0 sync,1 want d1,2 want blank,3 want d2,4 want blank
   logic [3:0] m_last, m_d1, m_d2;
   bit         m_last_vld;
   int         m_idle;
   logic       e_sv, e_pv, e_to, e_err;
   logic [3:0] e_code, e_d1, e_d2;
   logic [1:0] e_cause;

   function automatic logic [3:0] dec(input logic [6:0] v);
      logic [3:0] r;
      r = (v == 7'h00) ? 4'hA : 4'hF;
      for (int i = 0; i < 10; i++)
         if (v == c_pats[i]) r = 4'(i);
      return r;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic [6:0] s, input logic cc, input logic clr, input logic r);
      logic [6:0] n;
      logic [3:0] code;
      bit acc, stable, nerr;
      logic [1:0] ncause;
      if (r) begin
         hist.delete();
         m_state = 0; m_last = 0; m_last_vld = 0; m_idle = 0; m_d1 = 0; m_d2 = 0;
         e_sv = 0; e_pv = 0; e_to = 0; e_err = 0; e_code = 0; e_d1 = 0; e_d2 = 0; e_cause = 0;
         return;
      end
      n = cc ? s : ~s;
      acc = 0; code = 0; nerr = 0; ncause = 0;
      if (hist.size() >= STABLE) begin
         stable = 1;
         foreach (hist[i]) if (hist[i] != hist[hist.size()-1]) stable = 0;
         code = dec(hist[hist.size()-1]);
         acc  = stable && (!m_last_vld || code != m_last);
      end
      hist.push_back(n);
      if (hist.size() > STABLE) void'(hist.pop_front());
      e_sv = acc; e_pv = 0; e_to = 0;
      if (acc) begin
         e_code = code; m_last = code; m_last_vld = 1; m_idle = 0;
         if (code == 4'hF) begin
            nerr = 1; ncause = 2'b01; m_state = 0;
         end else if (code <= 9) begin
            case (m_state)
               1: begin m_d1 = code; m_state = 2; end
               3: begin m_d2 = code; m_state = 4; end
               2, 4: begin nerr = 1; ncause = 2'b10; m_state = 0; end
               default: ;
            endcase
         end else begin
            case (m_state)
               0: m_state = 1;
               2: m_state = 3;
               4: begin e_pv = 1; e_d1 = m_d1; e_d2 = m_d2; m_state = 1; end
               default: ;
            endcase
         end
      end else if (m_state != 0 && m_idle + 1 >= TMO) begin
         e_to = 1; m_state = 0; m_idle = 0;
      end else if (m_idle < TMO) begin
         m_idle++;
      end
      if (nerr) begin
         e_cause = (e_err && !clr) ? e_cause : ncause;
         e_err   = 1;
      end else if (clr) begin
         e_err = 0; e_cause = 0;
      end
   endtask

   task automatic step(input logic [6:0] s, input logic cc, input logic clr, input logic r);
      seg = s; common_cathode = cc; err_clr = clr; rst = r;
      @(posedge clk);
      model(s, cc, clr, r);
      #1;
      check("sym_valid", 8'(sym_valid), 8'(e_sv));
      if (e_sv) check("sym_code", 8'(sym_code), 8'(e_code));
      check("pair_valid", 8'(pair_valid), 8'(e_pv));
      check("dice1", 8'(dice1), 8'(e_d1));
      check("dice2", 8'(dice2), 8'(e_d2));
      check("timeout", 8'(timeout), 8'(e_to));
      check("err", 8'(err), 8'(e_err));
      check("err_cause", 8'(err_cause), 8'(e_cause));
   endtask

   // hold a normalized pattern n for k cycles under the given polarity
   task automatic hold(input logic [6:0] n, input logic cc, input int k);
      for (int i = 0; i < k; i++) step(cc ? n : ~n, cc, 1'b0, 1'b0);
   endtask

   int sv_count, pv_seen;

   initial begin
      seg = 0; common_cathode = 1; err_clr = 0; rst = 1;
      step(7'h00, 1'b1, 1'b0, 1'b1);
      step(7'h00, 1'b1, 1'b0, 1'b1);
      check("reset_sym_code", 8'(sym_code), 8'h00);
      check("reset_err", 8'(err), 8'h00);

      // pair (1,4), active-high then active-low lines
      hold(7'h00, 1, 6); hold(7'h06, 1, 6); hold(7'h00, 1, 6); hold(7'h66, 1, 6);
      pv_seen = 0;
      for (int i = 1; i <= 6; i++) begin
         step(7'h00, 1'b1, 1'b0, 1'b0);
         if (pair_valid) pv_seen = i;
      end
      check("pair_latency", 8'(pv_seen), 8'd5);
      check("t1_dice1", 8'(dice1), 8'd1);
      check("t1_dice2", 8'(dice2), 8'd4);
      hold(7'h00, 0, 6); hold(7'h06, 0, 6); hold(7'h00, 0, 6); hold(7'h66, 0, 6); hold(7'h00, 0, 6);
      check("t2_dice1", 8'(dice1), 8'd1);
      check("t2_dice2", 8'(dice2), 8'd4);

      // glitch inside a blank period, then pair (3,5)
      sv_count = 0;
      for (int i = 0; i < 3; i++) begin
         step(7'h5B, 1'b1, 1'b0, 1'b0);
         sv_count += int'(sym_valid);
      end
      hold(7'h00, 1, 6);
      check("glitch_no_sym", 8'(sv_count), 8'd0);
      hold(7'h4F, 1, 6); hold(7'h00, 1, 6); hold(7'h6D, 1, 6); hold(7'h00, 1, 6);
      check("t3_dice1", 8'(dice1), 8'd3);
      check("t3_dice2", 8'(dice2), 8'd5);

      // protocol violation, clear, then pair (1,1)
      hold(7'h4F, 1, 6); hold(7'h6D, 1, 6);
      check("proto_err", 8'(err), 8'd1);
      check("proto_cause", 8'(err_cause), 8'd2);
      step(7'h6D, 1'b1, 1'b1, 1'b0);
      check("clr_err", 8'(err), 8'd0);
      hold(7'h00, 1, 6); hold(7'h06, 1, 6); hold(7'h00, 1, 6); hold(7'h06, 1, 6); hold(7'h00, 1, 6);
      check("t4_dice1", 8'(dice1), 8'd1);
      check("t4_dice2", 8'(dice2), 8'd1);

      // invalid pattern, then a protocol error keeps the first cause
      hold(7'h49, 1, 6);
      check("inv_cause", 8'(err_cause), 8'd1);
      hold(7'h00, 1, 6); hold(7'h06, 1, 6); hold(7'h5B, 1, 6);
      check("inv_cause_kept", 8'(err_cause), 8'd1);
      step(7'h5B, 1'b1, 1'b1, 1'b0);

      // timeout mid-pair, then reset mid-pair
      hold(7'h00, 1, 6); hold(7'h06, 1, 30);
      check("to_dice1", 8'(dice1), 8'd1);
      hold(7'h00, 1, 6); hold(7'h06, 1, 6);
      step(7'h06, 1'b1, 1'b0, 1'b1);
      check("rst_dice1", 8'(dice1), 8'd0);

      // randomized streams
      for (int t = 0; t < 300; t++) begin
         logic [6:0] n;
         logic       cc;
         int         k, pick;
         pick = int'($urandom_range(0, 15));
         if (pick < 10)      n = c_pats[pick];
         else if (pick < 14) n = 7'h00;
         else                n = 7'($urandom);
         cc = 1'($urandom);
         k  = ($urandom_range(0, 19) == 0) ? 25 : int'($urandom_range(1, 8));
         for (int i = 0; i < k; i++)
            step(cc ? n : ~n, cc, ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
